// File: rtl/sram_rw_arbiter_if.sv
// sram_rw_arbiter_if: one requester's command/response bundle toward the SRAM arbiter.
interface sram_rw_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = DATA_WIDTH / 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [NUM_WMASKS-1:0] req_wmask;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  modport master (
    output req_valid, req_we, req_wmask, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );
  modport slave (
    input  req_valid, req_we, req_wmask, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_rw_arbiter.sv
// sram_rw_arbiter: round-robin two-requester sequencer for a 1RW OpenRAM macro with 2-cycle read return.
// Define SRAM_CLR_EN to zero every macro word after reset before any request is accepted.
module sram_rw_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_WMASKS = DATA_WIDTH / 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  sram_rw_arbiter_if.slave      a,
  sram_rw_arbiter_if.slave      b,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0,
  output logic                  init_done
);
  logic                  rr_b, grant_a, grant_b, grant, clr, run;
  logic                  req_we;
  logic [NUM_WMASKS-1:0] req_wmask;
  logic [ADDR_WIDTH-1:0] req_addr, clr_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  t1_v, t1_b, t2_v, t2_b;
`ifdef SRAM_CLR_EN
  typedef enum logic {CLEAR, RUN} state_t;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
  state_t state, state_nx;
  always_ff @(posedge clk0 or negedge rst0_n)
    if (!rst0_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= (clr && clr_addr != LAST_ADDR) ? clr_addr + 1'b1 : clr_addr;
    end
  always_comb begin
    state_nx = state;
    clr      = state == CLEAR;
    if (clr && clr_addr == LAST_ADDR) state_nx = RUN;
  end
  assign run       = state == RUN;
  assign init_done = run;
`else
  assign clr       = 1'b0;
  assign run       = 1'b1;
  assign clr_addr  = '0;
  assign init_done = 1'b1;
`endif
  // rr_b set means B wins a tie; a lone requester is always granted
  assign grant_a     = run & a.req_valid & (~b.req_valid | ~rr_b);
  assign grant_b     = run & b.req_valid & (~a.req_valid | rr_b);
  assign grant       = grant_a | grant_b;
  assign a.req_ready = grant_a;
  assign b.req_ready = grant_b;
  assign req_we      = grant_b ? b.req_we    : a.req_we;
  assign req_wmask   = grant_b ? b.req_wmask : a.req_wmask;
  assign req_addr    = grant_b ? b.req_addr  : a.req_addr;
  assign req_wdata   = grant_b ? b.req_wdata : a.req_wdata;
  always_ff @(posedge clk0 or negedge rst0_n)
    if (!rst0_n) begin
      rr_b        <= 1'b0;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      t1_v        <= 1'b0;
      t1_b        <= 1'b0;
      t2_v        <= 1'b0;
      t2_b        <= 1'b0;
    end else begin
      if (grant) rr_b <= grant_a;
      sram_csb0 <= ~(clr | grant);
      sram_web0 <= ~(clr | (grant & req_we));
      if (clr | grant) sram_addr0 <= clr ? clr_addr : req_addr;
      if (clr | (grant & req_we)) begin
        sram_wmask0 <= clr ? '1 : req_wmask;
        sram_din0   <= clr ? '0 : req_wdata;
      end
      // read ownership follows the macro's two-cycle return
      t1_v <= grant & ~req_we;
      t1_b <= grant_b;
      t2_v <= t1_v;
      t2_b <= t1_b;
    end
  always_ff @(posedge clk0 or negedge rst0_n)
    if (!rst0_n) begin
      a.rsp_valid <= 1'b0;
      b.rsp_valid <= 1'b0;
      a.rsp_rdata <= '0;
      b.rsp_rdata <= '0;
    end else begin
      a.rsp_valid <= t2_v & ~t2_b;
      b.rsp_valid <= t2_v & t2_b;
      if (t2_v & ~t2_b) a.rsp_rdata <= sram_dout0;
      if (t2_v & t2_b) b.rsp_rdata <= sram_dout0;
    end
endmodule

// File: tb/tb_sram_rw_arbiter.sv
// tb_sram_rw_arbiter: scoreboard bench for sram_rw_arbiter with a behavioural 1RW macro model.
module tb_sram_rw_arbiter;
`ifdef SRAM_CLR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  logic clk0 = 1'b0;
  logic rst0_n = 1'b0;
  always #5 clk0 = ~clk0;
  sram_rw_arbiter_if a_if ();
  sram_rw_arbiter_if b_if ();
  logic        sram_csb0, sram_web0, init_done;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0, sram_dout0;
  sram_rw_arbiter dut (
    .clk0(clk0), .rst0_n(rst0_n), .a(a_if), .b(b_if),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .init_done(init_done)
  );
  // macro model: inputs latched on posedge, array access on the following negedge
  logic        csb_q = 1'b1, web_q = 1'b1;
  logic [3:0]  wm_q;
  logic [7:0]  ad_q;
  logic [31:0] din_q;
  logic [31:0] mem [256];
  always @(posedge clk0) begin
    csb_q <= sram_csb0;
    web_q <= sram_web0;
    wm_q  <= sram_wmask0;
    ad_q  <= sram_addr0;
    din_q <= sram_din0;
  end
  always @(negedge clk0)
    if (!csb_q) begin
      if (!web_q) begin
        for (int i = 0; i < 4; i++) if (wm_q[i]) mem[ad_q][8*i +: 8] <= din_q[8*i +: 8];
      end else sram_dout0 <= mem[ad_q];
    end
  typedef struct {
    bit          side;
    logic [31:0] data;
    longint      t;
  } exp_t;
  exp_t        sb_q [$];
  logic [31:0] ref_mem [256];
  bit          rr_exp = 1'b0;
  int          n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive(input bit sb, input bit v, input bit we, input logic [7:0] ad, input logic [3:0] m, input logic [31:0] d);
    if (sb) begin
      b_if.req_valid = v; b_if.req_we = we; b_if.req_addr = ad; b_if.req_wmask = m; b_if.req_wdata = d;
    end else begin
      a_if.req_valid = v; a_if.req_we = we; a_if.req_addr = ad; a_if.req_wmask = m; a_if.req_wdata = d;
    end
  endtask
  task automatic accept(input bit sb, input bit we, input logic [7:0] ad, input logic [3:0] m, input logic [31:0] d, input bit want);
    exp_t e;
    if (we) begin
      for (int i = 0; i < 4; i++) if (m[i]) ref_mem[ad][8*i +: 8] = d[8*i +: 8];
    end else if (want) begin
      e.side = sb;
      e.data = ref_mem[ad];
      e.t    = longint'($time) + 25;
      sb_q.push_back(e);
    end
    rr_exp = ~sb;
  endtask
  task automatic issue(input bit sb, input bit we, input logic [7:0] ad, input logic [3:0] m, input logic [31:0] d, input bit want);
    int n = 0;
    @(negedge clk0);
    drive(sb, 1'b1, we, ad, m, d);
    #1;
    while (!(sb ? b_if.req_ready : a_if.req_ready) && n < 400) begin
      @(negedge clk0);
      #1;
      n++;
    end
    chk("ready_wait", 64'(n), 64'd0);
    if (n == 400) begin
      drive(sb, 1'b0, 1'b0, '0, '0, '0);
      return;
    end
    @(posedge clk0);
    accept(sb, we, ad, m, d, want);
    #1;
    drive(sb, 1'b0, 1'b0, '0, '0, '0);
    chk("sram_csb", sram_csb0, 0);
    chk("sram_web", sram_web0, !we);
    chk("sram_addr", sram_addr0, ad);
    if (we) begin
      chk("sram_wmask", sram_wmask0, m);
      chk("sram_din", sram_din0, d);
    end
  endtask
  task automatic wait_init();
    int n = 0;
    while (!init_done && n < 400) begin
      @(posedge clk0);
      #1;
      n++;
    end
    chk("init_cycles", 64'(n), CLR ? 64'd256 : 64'd0);
    if (CLR) for (int i = 0; i < 256; i++) ref_mem[i] = '0;
  endtask
  task automatic drain();
    repeat (6) @(negedge clk0);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
  endtask
  always @(negedge clk0)
    if (a_if.rsp_valid || b_if.rsp_valid) begin
      exp_t e;
      if (a_if.rsp_valid && b_if.rsp_valid) chk("rsp_both", 1, 0);
      if (sb_q.size() == 0) chk("rsp_unexpected", {a_if.rsp_valid, b_if.rsp_valid}, 0);
      else begin
        e = sb_q.pop_front();
        chk("rsp_side", b_if.rsp_valid, e.side);
        chk("rsp_data", e.side ? b_if.rsp_rdata : a_if.rsp_rdata, e.data);
        chk("rsp_time", $time, e.t);
      end
    end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int  n;
    bit  gb, seen;
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    // reset state, including the combinational grant while held in reset
    @(negedge clk0);
    drive(0, 1, 0, 8'h10, '0, '0);
    #1;
    chk("rst_csb", sram_csb0, 1);
    chk("rst_web", sram_web0, 1);
    chk("rst_rsp_valid", {a_if.rsp_valid, b_if.rsp_valid}, 0);
    chk("rst_a_ready", a_if.req_ready, !CLR);
    chk("rst_b_ready", b_if.req_ready, 0);
    chk("rst_init_done", init_done, !CLR);
    drive(1, 1, 0, 8'h11, '0, '0);
    #1;
    chk("rst_tie_a_ready", a_if.req_ready, !CLR);
    chk("rst_tie_b_ready", b_if.req_ready, 0);
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    @(negedge clk0);
    rst0_n = 1'b1;
    if (CLR) begin
      drive(1, 1, 0, 8'hFF, '0, '0);
      n = 0;
      seen = 1'b0;
      while (!init_done && n < 400) begin
        @(posedge clk0);
        #1;
        n++;
        seen |= b_if.req_ready;
      end
      chk("clr_cycles", 64'(n), 64'd256);
      chk("clr_ready_seen", seen, 0);
      chk("clr_ready_after", b_if.req_ready, 1);
      drive(1, 0, 0, '0, '0, '0);
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      issue(1, 0, 8'hFF, '0, '0, 1);
      drain();
    end
    issue(0, 1, 8'h10, 4'hF, 32'hDEADBEEF, 0);
    issue(0, 0, 8'h10, '0, '0, 1);
    drain();
    issue(0, 1, 8'h10, 4'h5, 32'h11223344, 0);
    issue(0, 0, 8'h10, '0, '0, 1);
    drain();
    issue(0, 1, 8'h01, 4'hF, 32'hA5A50101, 0);
    issue(1, 1, 8'h02, 4'hF, 32'h5A5A0202, 0);
    @(negedge clk0);
    drive(0, 1, 0, 8'h01, '0, '0);
    drive(1, 1, 0, 8'h02, '0, '0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("dual_a_ready", a_if.req_ready, !rr_exp);
      chk("dual_b_ready", b_if.req_ready, rr_exp);
      gb = rr_exp;
      @(posedge clk0);
      accept(gb, 0, gb ? 8'h02 : 8'h01, '0, '0, 1);
      @(negedge clk0);
    end
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    drain();
    for (int i = 0; i < 8; i++) issue(1'($urandom_range(0, 1)), 1, 8'h20 + 8'(i), 4'hF, $urandom, 0);
    for (int i = 0; i < 40; i++)
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'h20 + 8'($urandom_range(0, 7)),
            4'($urandom), $urandom, 1);
    drain();
    // reset lands while a read is in flight and csb0 is still low
    issue(0, 0, 8'h10, '0, '0, 0);
    #2;
    rst0_n = 1'b0;
    #1;
    chk("rst_async_csb", sram_csb0, 1);
    chk("rst_async_web", sram_web0, 1);
    repeat (4) begin
      @(negedge clk0);
      chk("rst_no_rsp", {a_if.rsp_valid, b_if.rsp_valid}, 0);
    end
    chk("rst_a_rdata", a_if.rsp_rdata, 0);
    @(negedge clk0);
    rst0_n = 1'b1;
    rr_exp = 1'b0;
    wait_init();
    issue(0, 1, 8'h10, 4'hF, 32'hCAFEF00D, 0);
    issue(1, 0, 8'h10, '0, '0, 1);
    issue(0, 0, 8'h10, '0, '0, 1);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
